// File: rtl/uart_tx_param_if.sv
// Handshake and line bundle between a byte producer and uart_tx_param.
interface uart_tx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                                 i_Tx_DV;
  logic [DATA_BITS-1:0]                 i_Tx_Byte;
  logic                                 o_Tx_Ready;
  logic                                 o_Tx_Active;
  logic                                 o_Tx_Serial;
  logic                                 o_Tx_Done;
  logic [$clog2(FIFO_DEPTH+1)-1:0]      o_Fifo_Count;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to buffer FIFO_DEPTH words and send frames back to back.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic            i_Clock,
  input logic            i_Rst_n,
  uart_tx_param_if.slave tx
);
  localparam bit PARAMS_OK = (CLKS_PER_BIT >= 2) && (CLKS_PER_BIT <= 65535) &&
                             (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                             (PARITY >= 0) && (PARITY <= 2) &&
                             (STOP_BITS == 1 || STOP_BITS == 2) &&
                             (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!PARAMS_OK) begin : gen_param_error
    $error("uart_tx_param: illegal parameter value");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;

  logic                 bitEnd, stopEnd, loadNow, wordAvail, readyNext;
  logic [DATA_BITS-1:0] wordData;

  assign bitEnd  = (cnt_q == CNT_MAX);
  assign stopEnd = (state_q == S_STOP) && bitEnd && (idx_q == IW'(STOP_BITS - 1));
  assign loadNow = wordAvail && ((state_q == S_IDLE) || stopEnd);

`ifdef UART_TX_FIFO_EN
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr_q, rdPtr_q;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 push, pop;

  // ready_q already reflects a full FIFO, so a push on full is dropped even during a pop
  assign push      = tx.i_Tx_DV && ready_q;
  assign pop       = loadNow;
  assign wordAvail = (count_q != '0);
  assign wordData  = mem_q[rdPtr_q];
  assign count_d   = count_q + CNTW'(push) - CNTW'(pop);
  assign readyNext = (count_d < CNTW'(FIFO_DEPTH));
  assign tx.o_Fifo_Count = count_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wrPtr_q] <= tx.i_Tx_Byte;
  end
`else
  assign wordAvail = tx.i_Tx_DV && ready_q;
  assign wordData  = tx.i_Tx_Byte;
  assign readyNext = (state_d == S_IDLE);
  assign tx.o_Fifo_Count = '0;
`endif

  // Outputs are computed one edge ahead so the line and flags come straight from flops
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (state_q != S_IDLE) cnt_d = bitEnd ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: ;
      S_START: if (bitEnd) begin
        state_d  = S_DATA;
        idx_d    = '0;
        serial_d = shift_q[0];
      end
      S_DATA: if (bitEnd) begin
        if (idx_q == IW'(DATA_BITS - 1)) begin
          idx_d = '0;
          if (PARITY != 0) begin
            state_d  = S_PARITY;
            serial_d = parity_q;
          end else begin
            state_d  = S_STOP;
            serial_d = 1'b1;
          end
        end else begin
          idx_d    = idx_q + IW'(1);
          shift_d  = shift_q >> 1;
          serial_d = shift_q[1];
        end
      end
      S_PARITY: if (bitEnd) begin
        state_d  = S_STOP;
        idx_d    = '0;
        serial_d = 1'b1;
      end
      S_STOP: if (bitEnd) begin
        if (stopEnd) begin
          done_d   = 1'b1;
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (loadNow) begin
      state_d  = S_START;
      cnt_d    = '0;
      idx_d    = '0;
      shift_d  = wordData;
      parity_d = (PARITY == 2) ? ~^wordData : ^wordData;
      serial_d = 1'b0;
      active_d = 1'b1;
    end
  end

  assign ready_d = readyNext;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_Tx_Ready  = ready_q;
endmodule
